// File: rtl/led_status_pkg.sv
// Shared types and helpers for the status-LED scheduler and its slow-rate tick source.
package led_status_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/led_status_scheduler_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks, reusable by other slow-rate blocks.
module tick_gen
    import led_status_pkg::*;
#(
    parameter int CLK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = clog2_min1(CLK_DIV);

    logic [CW-1:0] count;

    assign tick = (count == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_status_scheduler.sv
// Shares the status LED between an idle heartbeat and prioritised blink-code requesters.
//
//   state | meaning
//   IDLE  | heartbeat running, arbitrating requests on each tick
//   ON    | LED lit for one tick of the owner's blink code
//   OFF   | LED dark between blinks; decides next blink or the trailing gap
//   GAP   | trailing dark period, then done pulse and release
module led_status_scheduler
    import led_status_pkg::*;
#(
    parameter int CLK_DIV   = 12_500_000,
    parameter int N_REQ     = 4,
    parameter int HB_TICKS  = 2,
    parameter int GAP_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             led_out
);

    localparam int LW = clog2_min1(N_REQ);
    localparam int GW = clog2_min1(GAP_TICKS);
    localparam int HW = clog2_min1(HB_TICKS);

    logic          tick;
    state_t        state;
    logic [LW-1:0] win;
    logic [LW-1:0] left;
    logic [GW-1:0] gap;
    logic [HW-1:0] hb_cnt;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Lowest set index wins; scanning downward leaves the smallest one.
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win = LW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            led_out <= 1'b0;
            left    <= '0;
            gap     <= '0;
            hb_cnt  <= '0;
        end else begin
            done <= '0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (|req) begin
                            grant   <= N_REQ'(1) << win;
                            busy    <= 1'b1;
                            left    <= win;
                            led_out <= 1'b1;
                            state   <= ON;
                        end else if (hb_cnt == HW'(HB_TICKS - 1)) begin
                            led_out <= ~led_out;
                            hb_cnt  <= '0;
                        end else begin
                            hb_cnt <= hb_cnt + HW'(1);
                        end
                    end
                    ON: begin
                        led_out <= 1'b0;
                        state   <= OFF;
                    end
                    OFF: begin
                        if (left == '0) begin
                            gap   <= GW'(GAP_TICKS - 1);
                            state <= GAP;
                        end else begin
                            left    <= left - LW'(1);
                            led_out <= 1'b1;
                            state   <= ON;
                        end
                    end
                    GAP: begin
                        if (gap == '0) begin
                            done    <= grant;
                            grant   <= '0;
                            busy    <= 1'b0;
                            led_out <= 1'b0;
                            hb_cnt  <= '0;
                            state   <= IDLE;
                        end else begin
                            gap <= gap - GW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_status_scheduler.sv
// Scoreboard bench: stimulus queues expected codes and heartbeat toggles, a negedge monitor checks them.
module tb_led_status_scheduler;

    localparam int CLK_DIV   = 4;
    localparam int N_REQ     = 4;
    localparam int HB_TICKS  = 2;
    localparam int GAP_TICKS = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             busy;
    logic             led_out;

    led_status_scheduler #(
        .CLK_DIV   (CLK_DIV),
        .N_REQ     (N_REQ),
        .HB_TICKS  (HB_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] owner;
        int         pulses;
        int         dur;
    } code_t;

    typedef struct {
        int   cyc;
        logic val;
    } hb_t;

    code_t code_q[$];
    hb_t   hb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc;
    int ndone = 0;
    bit hb_watch = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    logic [3:0] g_val = '0;
    logic       prev_led = 1'b0;
    bit         in_code = 0;
    bit         grant_bad = 0;
    bit         busy_bad = 0;
    int         g_start = 0;
    int         pulses = 0;

    always @(negedge clk) begin
        code_t e;
        hb_t   h;
        if (!rst_n) begin
            in_code   = 0;
            grant_bad = 0;
        end else begin
            if (busy != (|grant)) busy_bad = 1;
            if (!in_code && grant != '0) begin
                in_code = 1;
                g_start = cyc;
                g_val   = grant;
                pulses  = led_out ? 1 : 0;
            end else if (in_code && grant != '0) begin
                if (grant != g_val) grant_bad = 1;
                if (led_out && !prev_led) pulses++;
            end
            if (done != '0) begin
                ndone++;
                if (code_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=%b expected none (cycle %0d)", done, cyc);
                end else begin
                    e = code_q.pop_front();
                    check("done_bits", int'(done), int'(e.owner));
                    check("grant_owner", int'(g_val), int'(e.owner));
                    check("pulse_count", pulses, e.pulses);
                    check("code_cycles", cyc - g_start, e.dur);
                    check("grant_cleared", int'(grant), 0);
                    check("grant_stable", int'(grant_bad), 0);
                end
                in_code   = 0;
                grant_bad = 0;
            end
            if (hb_watch && led_out != prev_led) begin
                if (hb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_toggle: got led_out=%0b expected no change (cycle %0d)", led_out, cyc);
                end else begin
                    h = hb_q.pop_front();
                    check("hb_cycle", cyc, h.cyc);
                    check("hb_level", int'(led_out), int'(h.val));
                end
            end
        end
        prev_led = led_out;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic wait_ndone(input int target, input int limit);
        for (int i = 0; i < limit && ndone < target; i++) step();
        if (ndone < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", ndone, target);
        end
    endtask

    task automatic wait_grant(input int limit);
        for (int i = 0; i < limit && grant == '0; i++) step();
        if (grant == '0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got grant=0 expected nonzero");
        end
    endtask

    task automatic push_code(input logic [3:0] owner, input int idx);
        code_t e;
        e.owner  = owner;
        e.pulses = idx + 1;
        e.dur    = (2 * (idx + 1) + GAP_TICKS) * CLK_DIV;
        code_q.push_back(e);
    endtask

    task automatic push_hb(input int n);
        hb_t h;
        for (int k = 1; k <= n; k++) begin
            h.cyc = 8 * k;
            h.val = k[0];
            hb_q.push_back(h);
        end
    endtask

    initial begin
        // Reset state
        #22;
        check("rst_led", int'(led_out), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);

        // Idle heartbeat: toggles every 8 cycles, first at cycle 8
        push_hb(5);
        hb_watch = 1;
        step();
        rst_n = 1'b1;
        wait_cyc(41);
        hb_watch = 0;
        check("hb_remaining", hb_q.size(), 0);

        // Requester 2: three pulses, done 32 cycles after grant
        push_code(4'b0100, 2);
        req = 4'b0100;
        wait_ndone(1, 200);
        req = '0;

        // Simultaneous 1 and 3: 1 wins, 3 follows on next idle tick
        step();
        push_code(4'b0010, 1);
        push_code(4'b1000, 3);
        req = 4'b1010;
        wait_ndone(2, 200);
        req = 4'b1000;
        wait_ndone(3, 200);
        req = '0;

        // Requester 0 drops right after grant while 3 arrives mid-code
        step();
        push_code(4'b0001, 0);
        req = 4'b0001;
        wait_grant(50);
        req = 4'b1000;
        push_code(4'b1000, 3);
        wait_ndone(5, 200);
        req = '0;

        // Reset during ON aborts the code without a done pulse
        step();
        req = 4'b0100;
        wait_grant(50);
        check("on_led_before_reset", int'(led_out), 1);
        rst_n = 1'b0;
        #1;
        check("abort_led", int'(led_out), 0);
        check("abort_grant", int'(grant), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        req = '0;
        repeat (3) step();
        check("abort_ndone", ndone, 5);
        push_hb(3);
        hb_watch = 1;
        rst_n = 1'b1;
        wait_cyc(25);
        hb_watch = 0;
        check("hb_after_reset_remaining", hb_q.size(), 0);

        check("codes_remaining", code_q.size(), 0);
        check("busy_tracks_grant", int'(busy_bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_status_scheduler.md
# led_status_scheduler

Controller that shares the single board status LED between a free-running heartbeat and up to N_REQ event requesters. While idle it drives a 50% duty heartbeat. On a request it grants the LED to one requester, plays that requester's blink code (index+1 blinks), inserts a dark gap, then signals completion. It sits between the system status sources and the LED pin, and supersedes a bare heartbeat divider.

## Interface
- CLK_DIV, 12_500_000: clk cycles per tick; tick period is exactly CLK_DIV cycles (0.25 s at 50 MHz); must be ≥2.
- N_REQ, 4: number of requesters; index 0 has the highest priority; must be ≥1.
- HB_TICKS, 2: ticks per heartbeat half-period; must be ≥1.
- GAP_TICKS, 4: dark ticks after a blink code; must be ≥1.

- clk  in  1  main device clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per source; held high until done is seen.
- grant  out  N_REQ  one-hot owner of the LED; all zero when idle.
- done  out  N_REQ  one-cycle pulse on the owner's bit when its code finishes.
- busy  out  1  high while any code is playing (grant != 0).
- led_out  out  1  LED drive, active high.

## Operation
- Tick: counter runs 0..CLK_DIV-1 and wraps. tick is high for the one cycle when count==CLK_DIV-1. All state changes below happen only on tick cycles, except reset and the done/grant clear.
- States: IDLE, ON, OFF, GAP.
- IDLE: heartbeat. hb_cnt counts ticks. On tick with hb_cnt==HB_TICKS-1, led_out toggles and hb_cnt returns to 0.
- IDLE, tick, req!=0: arbitration wins over the heartbeat on the same tick.
  - Fixed priority: lowest set index i.
  - grant<=onehot(i), left<=i, led_out<=1, state<=ON.
  - req is sampled only on this cycle; req changes during the grant are ignored.
- ON, tick: led_out<=0, state<=OFF.
- OFF, tick:
  - left==0: gap<=GAP_TICKS-1, state<=GAP.
  - else: left<=left-1, led_out<=1, state<=ON.
- GAP, tick:
  - gap==0: state<=IDLE, done[i]<=1 for one cycle, grant<=0, led_out<=0, hb_cnt<=0.
  - else: gap<=gap-1.
- Requester i therefore gets exactly i+1 one-tick pulses, separated by one-tick dark periods. The code ends with 1+GAP_TICKS dark ticks.
- Dropping req mid-code does not abort; the code completes and done still pulses.
- A requester still high after done may be re-granted at the next idle tick. Arbitration is not fair; starvation of high indices is accepted.
- The tick counter free-runs in all states and is never reset by arbitration.

## Timing
- Reset (async assert) forces: led_out=0, grant=0, done=0, busy=0, state=IDLE, all counters 0.
  - Reset mid-code aborts the code with no done pulse.
  - After release, the first tick occurs CLK_DIV cycles after the first active edge.
- Latency: req high one or more cycles before a tick is granted on that tick edge, so grant and led_out are visible the cycle after the tick. Worst-case wait from an idle state is CLK_DIV cycles.
- Code duration for requester i: (2·(i+1)+GAP_TICKS) ticks from the grant edge to the done edge.
- done and grant-clear occur on the same edge; busy == |grant, registered.
- Widths: tick counter $clog2(CLK_DIV); left $clog2(N_REQ) (min 1); gap $clog2(GAP_TICKS) (min 1); hb_cnt $clog2(HB_TICKS) (min 1).

## Structure
- Shared package led_status_pkg:
  - state enum (IDLE, ON, OFF, GAP), 2 bits;
  - a clog2-min-1 width helper function.
- Sub-module tick_gen: parameter CLK_DIV; ports clk, rst_n, tick. It is reusable by other slow-rate blocks.
- The remaining logic (priority encoder, FSM, counters) stays in led_status_scheduler.

## Test plan
Bench parameters: CLK_DIV=4, N_REQ=4, HB_TICKS=2, GAP_TICKS=2.
- Idle, no req, 40 cycles → led_out toggles every 8 cycles; first toggle on the 2nd tick (cycle 8); grant=0, done=0.
- req=4'b0100 held → grant=0100 on tick; 3 one-tick pulses on led_out; done[2] pulses 32 cycles after the grant edge; busy high throughout.
- req=4'b1010 simultaneously → grant=0010 (1 blink), done[1]. Next idle tick → grant=1000 (4 blinks), done[3].
- req[3] asserted during code of requester 0 → not granted until requester 0's done; requester 0 emits exactly 1 pulse.
- Deassert req[0] right after grant → code completes; done[0] still pulses once.
- Assert rst_n=0 mid-ON → immediately led_out=0, grant=0, busy=0, no done. After release, heartbeat resumes from hb_cnt=0.
